// File: rtl/pipelined_tree_multiplier.sv
// Three-stage valid/ready WIDTH x WIDTH multiplier: AND-array partial products, CSA tree, final CPA.
// Define SIGNED_MULT_EN to honour sgn through Baugh-Wooley correction; otherwise every operation is unsigned.
module pipelined_tree_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;
  // One row per multiplier bit plus one row carrying the signed-mode constant ones.
  localparam int NR = WIDTH + 1;

  function automatic int tree_levels();
    int r;
    int l;
    r = NR;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = tree_levels();

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  logic [WIDTH-1:0] pp_next [WIDTH];
  logic [WIDTH-1:0] pp_s1   [WIDTH];
  logic [PW-1:0]    sum_next, carry_next;
  logic [PW-1:0]    sum_s2, carry_s2;

`ifdef SIGNED_MULT_EN
  logic sgn_s1;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  // A stage may load whenever it is empty or its current beat is leaving this cycle.
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1 && !rst;
  assign out_valid = v3;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_next[i] = a & {WIDTH{b[i]}};
`ifdef SIGNED_MULT_EN
      // Baugh-Wooley: invert products that pair exactly one sign bit with a magnitude bit.
      if (sgn) begin
        if (i == WIDTH - 1) pp_next[i][WIDTH-2:0] = ~pp_next[i][WIDTH-2:0];
        else                pp_next[i][WIDTH-1]   = ~pp_next[i][WIDTH-1];
      end
`endif
    end
  end

  always_comb begin
    logic [PW-1:0] cur [NR];
    logic [PW-1:0] nxt [NR];
    int cnt;
    int n;
    for (int i = 0; i < WIDTH; i++) cur[i] = PW'(pp_s1[i]) << i;
    cur[WIDTH] = '0;
`ifdef SIGNED_MULT_EN
    if (sgn_s1) begin
      cur[WIDTH][WIDTH] = 1'b1;
      cur[WIDTH][PW-1]  = 1'b1;
    end
`endif
    for (int r = 0; r < NR; r++) nxt[r] = '0;
    cnt = NR;
    // Wallace-style levels: each full group of three rows becomes a sum row and a shifted carry row.
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      n = 0;
      for (int r = 0; r < NR; r++) nxt[r] = '0;
      for (int g = 0; g < NR / 3; g++) begin
        if (3 * g + 2 < cnt) begin
          nxt[n]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
          nxt[n + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
          n = n + 2;
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (r >= 3 * (cnt / 3) && r < cnt) begin
          nxt[n] = cur[r];
          n = n + 1;
        end
      end
      cur = nxt;
      cnt = n;
    end
    sum_next   = cur[0];
    carry_next = cur[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      for (int i = 0; i < WIDTH; i++) pp_s1[i] <= '0;
      sum_s2   <= '0;
      carry_s2 <= '0;
      p        <= '0;
`ifdef SIGNED_MULT_EN
      sgn_s1   <= 1'b0;
`endif
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          pp_s1  <= pp_next;
`ifdef SIGNED_MULT_EN
          sgn_s1 <= sgn;
`endif
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          sum_s2   <= sum_next;
          carry_s2 <= carry_next;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) p <= sum_s2 + carry_s2;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Bench for pipelined_tree_multiplier: an 8-bit instance for directed/random streams and a 4-bit one for the exhaustive sweep.
`timescale 1ns/1ps
module tb_pipelined_tree_multiplier;

`ifdef SIGNED_MULT_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        in_valid4, in_ready4, sgn4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks = 0;
  int failures = 0;

  pipelined_tree_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  pipelined_tree_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .sgn(sgn4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
  );

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (s && SIGNED_EN) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end
    return 16'(xi * yi);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (s && SIGNED_EN) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end
    return 8'(xi * yi);
  endfunction

  // Single beat on the 8-bit instance; lat counts rising edges from the accepting edge to out_valid.
  task automatic run_single8(input logic [7:0] x, input logic [7:0] y, input logic s,
                             output logic [15:0] prod, output int lat);
    @(negedge clk);
    a8 = x; b8 = y; sgn8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    prod = p8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid8 got=%0b want=0", out_valid8); end
    checks++; if (p8 !== 16'h0) begin failures++; $display("[TB] FAIL reset_p8 got=%h want=0000", p8); end
    checks++; if (in_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready8 got=%0b want=0", in_ready8); end
    checks++; if (out_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid4 got=%0b want=0", out_valid4); end
    checks++; if (p4 !== 8'h0) begin failures++; $display("[TB] FAIL reset_p4 got=%h want=00", p4); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready8 got=%0b want=1", in_ready8); end
    checks++; if (in_ready4 !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready4 got=%0b want=1", in_ready4); end
  endtask

  task automatic test_unsigned_latency();
    logic [15:0] prod;
    int lat;
    run_single8(8'hFF, 8'hFF, 1'b0, prod, lat);
    checks++; if (prod !== 16'hFE01) begin failures++; $display("[TB] FAIL u255x255 got=%h want=fe01", prod); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL latency got=%0d want=3", lat); end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      run_single8(x, y, 1'b0, prod, lat);
      checks++; if (prod !== ref8(x, y, 1'b0)) begin failures++; $display("[TB] FAIL u_single a=%h b=%h got=%h want=%h", x, y, prod, ref8(x, y, 1'b0)); end
    end
  endtask

  task automatic test_signed_modes();
    logic [7:0]  xs [4] = '{8'h80, 8'hFF, 8'hFF, 8'h7F};
    logic [7:0]  ys [4] = '{8'h80, 8'h7F, 8'h7F, 8'h80};
    logic        ss [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] prod;
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_single8(xs[k], ys[k], ss[k], prod, lat);
      checks++; if (prod !== ref8(xs[k], ys[k], ss[k])) begin failures++; $display("[TB] FAIL sgn_case%0d a=%h b=%h s=%0b got=%h want=%h", k, xs[k], ys[k], ss[k], prod, ref8(xs[k], ys[k], ss[k])); end
    end
  endtask

  task automatic test_back_pressure();
    int next_beat, got;
    bit started;
    next_beat = 1; got = 0; started = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready8 = (cyc >= 6);
      in_valid8  = (next_beat <= 5);
      a8 = 8'(next_beat); b8 = 8'd3; sgn8 = 1'b0;
      #1;
      if (cyc == 4) begin
        checks++; if (out_valid8 !== 1'b1 || p8 !== ref8(8'd1, 8'd3, 1'b0)) begin failures++; $display("[TB] FAIL stall_hold valid=%0b p=%h want p=%h", out_valid8, p8, ref8(8'd1, 8'd3, 1'b0)); end
      end
      if (cyc == 5) begin
        checks++; if (next_beat - 1 !== 3) begin failures++; $display("[TB] FAIL bp_accepted got=%0d want=3", next_beat - 1); end
        checks++; if (in_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready got=%0b want=0", in_ready8); end
      end
      if (cyc == 6) begin
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL bp_full_pass in_ready got=%0b want=1", in_ready8); end
      end
      if (out_valid8 && out_ready8) begin
        got++;
        started = 1'b1;
        checks++; if (p8 !== ref8(8'(got), 8'd3, 1'b0)) begin failures++; $display("[TB] FAIL bp_order beat=%0d got=%h want=%h", got, p8, ref8(8'(got), 8'd3, 1'b0)); end
      end else if (started) begin
        checks++; failures++; $display("[TB] FAIL bp_gap got=%0d beats before bubble want=5", got);
      end
      if (in_valid8 && in_ready8) next_beat++;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    checks++; if (got !== 5) begin failures++; $display("[TB] FAIL bp_count got=%0d want=5", got); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] prod;
    int lat;
    bit seen;
    @(negedge clk);
    out_ready8 = 1'b0; in_valid8 = 1'b1; a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0;
    @(negedge clk);
    a8 = 8'd11;
    @(negedge clk);
    in_valid8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_in_ready got=%0b want=0", in_ready8); end
    rst = 1'b0; out_ready8 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid8 !== 1'b0 || p8 !== 16'h0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("[TB] FAIL mid_rst_ghost out_valid=%0b p=%h want valid=0 p=0000", out_valid8, p8); end
    run_single8(8'd5, 8'd6, 1'b0, prod, lat);
    checks++; if (prod !== ref8(8'd5, 8'd6, 1'b0) || lat !== 3) begin failures++; $display("[TB] FAIL mid_rst_first got=%h lat=%0d want=%h lat=3", prod, lat, ref8(8'd5, 8'd6, 1'b0)); end
  endtask

  task automatic test_random8();
    logic [15:0] exp_q [$];
    logic [15:0] e;
    int sent, recv;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 3000 && recv < 300; cyc++) begin
      @(negedge clk);
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (!in_valid8 || in_ready8) begin
        in_valid8 = (sent < 300) && ($urandom_range(0, 4) != 0);
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end
      #1;
      if (out_valid8 && out_ready8) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL rand8_extra got=%h want=none", p8); end
        else begin
          e = exp_q.pop_front();
          if (p8 !== e) begin failures++; $display("[TB] FAIL rand8 idx=%0d got=%h want=%h", recv, p8, e); end
        end
        recv++;
      end
      if (in_valid8 && in_ready8) begin
        exp_q.push_back(ref8(a8, b8, sgn8));
        sent++;
      end
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    checks++; if (recv !== 300) begin failures++; $display("[TB] FAIL rand8_count got=%0d want=300", recv); end
  endtask

  task automatic test_exhaustive4();
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [8:0] idx;
    int sent, recv;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 5000 && recv < 512; cyc++) begin
      @(negedge clk);
      out_ready4 = ($urandom_range(0, 3) != 0);
      in_valid4  = (sent < 512);
      idx = 9'(sent);
      a4 = idx[3:0]; b4 = idx[7:4]; sgn4 = idx[8];
      #1;
      if (out_valid4 && out_ready4) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL exh4_extra got=%h want=none", p4); end
        else begin
          e = exp_q.pop_front();
          if (p4 !== e) begin failures++; $display("[TB] FAIL exh4 idx=%0d got=%h want=%h", recv, p4, e); end
        end
        recv++;
      end
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(ref4(a4, b4, sgn4));
        sent++;
      end
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    checks++; if (recv !== 512) begin failures++; $display("[TB] FAIL exh4_count got=%0d want=512", recv); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sgn8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sgn4 = 1'b0; out_ready4 = 1'b1;
    test_reset();
    test_unsigned_latency();
    test_signed_modes();
    test_back_pressure();
    test_reset_midflight();
    test_random8();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
